// File: rtl/cell_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : screen (package)
//  Description : Shared constants, types and helpers for the Sudoku screen
//                cell scan path: grid size, cell index type, scan FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package screen;

    // Default board edge length (cells per row and per column)
    localparam int GRID_N = 9;

    // Board RAM address width; row*GRID_N+col fits for GRID_N up to 11
    localparam int ADDR_W = 7;

    // Width of a row/column index and of a stored digit
    localparam int IDX_W  = 4;

    typedef logic [IDX_W-1:0] cell_index_t;

    // Scan sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EVAL    = 3'd2,
        REQ     = 3'd3,
        ADVANCE = 3'd4,
        DONE    = 3'd5
    } scan_state_t;

    // A cell holds a drawable digit only when its code is 1..9
    function automatic logic is_digit(input logic [IDX_W-1:0] code);
        return (code >= 4'd1) && (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_scan_sequencer_grid_rc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : grid_rc_counter
//  Description : Row-major row/column position counter for a GRID_N x GRID_N
//                board. Clear returns to (0,0); advance steps one cell with
//                column wrap into the next row. Also exposes the position the
//                next advance would produce and a last-cell flag.
//  Revision    : 1.0  initial release
// ============================================================================
module grid_rc_counter
    import screen::*;
#(
    parameter int GRID_N = screen::GRID_N
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_advance,
    output logic [3:0]  o_row,
    output logic [3:0]  o_col,
    output logic [3:0]  o_next_row,
    output logic [3:0]  o_next_col,
    output logic        o_last
);

    localparam cell_index_t C_LAST = cell_index_t'(GRID_N - 1);

    cell_index_t r_row;
    cell_index_t r_col;
    cell_index_t w_next_row;
    cell_index_t w_next_col;
    logic        w_col_wrap;

    assign w_col_wrap = (r_col == C_LAST);

    // Position after one advance; the row saturates at the last row
    always_comb begin
        w_next_row = r_row;
        w_next_col = r_col;
        if (!w_col_wrap) begin
            w_next_col = r_col + 4'd1;
        end else begin
            w_next_col = '0;
            if (r_row != C_LAST) begin
                w_next_row = r_row + 4'd1;
            end
        end
    end

    // Position register: clear has priority over advance
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            r_row <= w_next_row;
            r_col <= w_next_col;
        end
    end

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_next_row = w_next_row;
    assign o_next_col = w_next_col;
    assign o_last     = (r_row == C_LAST) && w_col_wrap;

endmodule
`default_nettype wire

// File: rtl/cell_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cell_scan_sequencer
//  Description : Walks every board cell in row-major order, reads its digit
//                from the board RAM (one-cycle read latency) and issues a
//                draw request per cell to the glyph drawer, holding the cell
//                coordinates and digit stable until the drawer acknowledges.
//                Empty cells are optionally skipped. One done pulse per scan.
//  Revision    : 1.0  initial release
// ============================================================================
module cell_scan_sequencer
    import screen::*;
#(
    parameter bit SKIP_EMPTY = 1'b1,
    parameter int GRID_N     = screen::GRID_N
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [6:0]  board_rd_addr,
    input  logic [3:0]  board_rd_data,
    output logic [3:0]  cell_row,
    output logic [3:0]  cell_col,
    output logic [3:0]  cell_digit,
    output logic        draw_req,
    input  logic        draw_ack,
    output logic        busy,
    output logic        done
);

    localparam logic [ADDR_W-1:0] C_GRID_N_A = ADDR_W'(GRID_N);

    scan_state_t         r_state;
    logic [ADDR_W-1:0]   r_addr;
    cell_index_t         r_digit;
    logic                r_draw_req;
    logic                r_busy;
    logic                r_done;

    logic                w_clear;
    logic                w_advance;
    logic                w_last;
    logic                w_draw_cell;
    cell_index_t         w_row;
    cell_index_t         w_col;
    cell_index_t         w_next_row;
    cell_index_t         w_next_col;
    logic [ADDR_W-1:0]   w_next_addr;

    // A scan starts only from IDLE; the last cell leaves the counter parked
    assign w_clear   = (r_state == IDLE) && start;
    assign w_advance = (r_state == ADVANCE) && !w_last;

    grid_rc_counter #(
        .GRID_N     (GRID_N)
    ) u_rc_counter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_advance  (w_advance),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_next_row (w_next_row),
        .o_next_col (w_next_col),
        .o_last     (w_last)
    );

    // Address of the cell the counter moves to, so it is ready for FETCH
    assign w_next_addr = ADDR_W'(w_next_row) * C_GRID_N_A + ADDR_W'(w_next_col);

    // Empty and out-of-range codes are drawn only when skipping is disabled
    assign w_draw_cell = is_digit(board_rd_data) || !SKIP_EMPTY;

    // Scan FSM with registered address, digit and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_digit    <= '0;
            r_draw_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    // RAM samples the address at the end of this cycle
                    r_state <= EVAL;
                end
                EVAL: begin
                    r_digit <= board_rd_data;
                    if (w_draw_cell) begin
                        r_draw_req <= 1'b1;
                        r_state    <= REQ;
                    end else begin
                        r_state    <= ADVANCE;
                    end
                end
                REQ: begin
                    if (draw_ack) begin
                        r_draw_req <= 1'b0;
                        r_state    <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_addr  <= w_next_addr;
                        r_state <= FETCH;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_draw_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign board_rd_addr = r_addr;
    assign cell_row      = w_row;
    assign cell_col      = w_col;
    assign cell_digit    = r_digit;
    assign draw_req      = r_draw_req;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cell_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_scan_sequencer
//  Description : Self-checking bench for cell_scan_sequencer. A board model
//                predicts, per cycle after the start edge, which cells are
//                fetched, when each draw request is shown and for how long,
//                and when done fires; one compare process checks the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cell_scan_sequencer;

    localparam int N    = 9;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic ack_force = 1'b0;
    logic ack_auto = 1'b0;
    bit   sel0 = 1'b0;

    // instance with skipping (suffix 1) and without skipping (suffix 0)
    logic [6:0] addr1, addr0;
    logic [3:0] rd1, rd0;
    logic [3:0] row1, row0, col1, col0, dig1, dig0;
    logic       req1, req0, busy1, busy0, done1, done0;
    logic       start1, start0, ack1, ack0;

    logic [3:0] board [128];

    always #5 clk = ~clk;

    assign start1 = start & ~sel0;
    assign start0 = start & sel0;
    assign ack1   = (ack_auto | ack_force) & ~sel0;
    assign ack0   = (ack_auto | ack_force) & sel0;

    cell_scan_sequencer #(.SKIP_EMPTY(1'b1), .GRID_N(N)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .board_rd_addr(addr1), .board_rd_data(rd1),
        .cell_row(row1), .cell_col(col1), .cell_digit(dig1),
        .draw_req(req1), .draw_ack(ack1), .busy(busy1), .done(done1)
    );

    cell_scan_sequencer #(.SKIP_EMPTY(1'b0), .GRID_N(N)) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .board_rd_addr(addr0), .board_rd_data(rd0),
        .cell_row(row0), .cell_col(col0), .cell_digit(dig0),
        .draw_req(req0), .draw_ack(ack0), .busy(busy0), .done(done0)
    );

    // board RAM: data one cycle after address
    always @(posedge clk) begin
        rd1 <= board[addr1];
        rd0 <= board[addr0];
    end

    logic [6:0] m_addr;
    logic [3:0] m_row, m_col, m_dig;
    logic       m_req, m_busy, m_done;
    assign m_addr = sel0 ? addr0 : addr1;
    assign m_row  = sel0 ? row0  : row1;
    assign m_col  = sel0 ? col0  : col1;
    assign m_dig  = sel0 ? dig0  : dig1;
    assign m_req  = sel0 ? req0  : req1;
    assign m_busy = sel0 ? busy0 : busy1;
    assign m_done = sel0 ? done0 : done1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         exp_req   [MAXC];
    bit         exp_fetch [MAXC];
    logic [6:0] exp_addr  [MAXC];
    logic [3:0] exp_row   [MAXC];
    logic [3:0] exp_col   [MAXC];
    logic [3:0] exp_dig   [MAXC];
    int         done_cyc;
    int         n_req;
    int         ack_w = 1;

    // Every cell costs fetch+evaluate+advance; a drawn cell also shows its
    // request for w cycles between evaluate and advance.
    task automatic build_model(input bit skip, input int w);
        int t;
        for (int i = 0; i < MAXC; i++) begin
            exp_req[i] = 1'b0;
            exp_fetch[i] = 1'b0;
        end
        t = 1;
        n_req = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_fetch[t] = 1'b1;
                exp_addr[t]  = 7'(r * N + c);
                if (!skip || (board[r*N+c] >= 1 && board[r*N+c] <= 9)) begin
                    for (int j = 0; j < w; j++) begin
                        exp_req[t+2+j] = 1'b1;
                        exp_row[t+2+j] = 4'(r);
                        exp_col[t+2+j] = 4'(c);
                        exp_dig[t+2+j] = board[r*N+c];
                    end
                    n_req++;
                    t += 3 + w;
                end else begin
                    t += 3;
                end
            end
        end
        done_cyc = t;
    endtask

    // ---------------- compare process ----------------
    bit track = 1'b0;
    int cyc = 0;
    int obs_done = 0;
    int obs_req = 0;

    always @(negedge clk) begin
        if (!track) begin
            cyc = 0;
            obs_done = 0;
            obs_req = 0;
        end else begin
            cyc++;
            chk("busy", m_busy, (cyc >= 1 && cyc <= done_cyc));
            chk("done", m_done, (cyc == done_cyc));
            chk("draw_req", m_req, exp_req[cyc]);
            if (m_done) obs_done = cyc;
            if (m_req) obs_req++;
            if (exp_req[cyc]) begin
                chk("cell_row", m_row, exp_row[cyc]);
                chk("cell_col", m_col, exp_col[cyc]);
                chk("cell_digit", m_dig, exp_dig[cyc]);
            end
            if (exp_fetch[cyc]) chk("rd_addr", m_addr, exp_addr[cyc]);
        end
    end

    // glyph drawer: acknowledges in the ack_w-th cycle of each request
    int ack_cnt = 0;
    always @(negedge clk) begin
        if (m_req) begin
            ack_cnt++;
            ack_auto = (ack_cnt >= ack_w);
        end else begin
            ack_cnt = 0;
            ack_auto = 1'b0;
        end
    end

    // One scan; sa/sb (>0) are cycles in which an extra start is driven
    task automatic run_scan(input bit use0, input int w, input int sa, input int sb);
        int end_cyc;
        sel0  = use0;
        ack_w = w;
        build_model(!use0, w);
        end_cyc = done_cyc + 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        track = 1'b1;
        for (int k = 0; k < 6000 && cyc < end_cyc; k++) begin
            @(posedge clk);
            #1;
            start = ((sa > 0) && (cyc + 1 == sa)) || ((sb > 0) && (cyc + 1 == sb));
        end
        start = 1'b0;
        track = 1'b0;
        chk("scan_completed", (cyc >= end_cyc), 1'b1);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 128; i++) board[i] = 4'd0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_board();
        repeat (3) @(posedge clk);
        @(negedge clk);
        // reset state of both instances
        chk("rst_busy1", busy1, 0);   chk("rst_req1", req1, 0);
        chk("rst_done1", done1, 0);   chk("rst_addr1", addr1, 0);
        chk("rst_row1", row1, 0);     chk("rst_col1", col1, 0);
        chk("rst_dig1", dig1, 0);     chk("rst_busy0", busy0, 0);
        chk("rst_req0", req0, 0);
        reset = 1'b0;

        // ack in IDLE has no effect
        ack_force = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ack_busy", m_busy, 0);
        chk("idle_ack_req", m_req, 0);
        ack_force = 1'b0;

        // all-empty board, skipping
        run_scan(1'b0, 1, 0, 0);
        chk("model_empty_done", done_cyc, 244);
        chk("model_empty_nreq", n_req, 0);
        chk("empty_done_cycle", obs_done, 244);
        chk("empty_req_cycles", obs_req, 0);

        // full board, immediate ack
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                board[r*N+c] = 4'((r + c) % 9 + 1);
        run_scan(1'b0, 1, 0, 0);
        chk("model_full_done", done_cyc, 325);
        chk("model_full_nreq", n_req, 81);
        chk("full_done_cycle", obs_done, 325);
        chk("full_req_cycles", obs_req, 81);

        // start while busy and in the DONE cycle is ignored
        run_scan(1'b0, 1, 50, 325);
        chk("restart_done_cycle", obs_done, 325);

        // single digit with a slow drawer
        clear_board();
        board[4*N+7] = 4'd5;
        run_scan(1'b0, 10, 0, 0);
        chk("model_single_done", done_cyc, 254);
        chk("model_single_dig", exp_dig[1 + 43*3 + 2], 5);
        chk("single_req_cycles", obs_req, 10);
        chk("single_done_cycle", obs_done, 254);

        // reset in the middle of a request
        clear_board();
        board[2*N+3] = 4'd7;
        sel0  = 1'b0;
        ack_w = 50;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 500 && !m_req; k++) @(negedge clk);
        chk("mid_req_seen", m_req, 1);
        chk("mid_req_row", m_row, 2);
        chk("mid_req_col", m_col, 3);
        chk("mid_req_dig", m_dig, 7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_req", m_req, 0);
        chk("abort_busy", m_busy, 0);
        chk("abort_row", m_row, 0);
        chk("abort_col", m_col, 0);
        chk("abort_dig", m_dig, 0);
        chk("abort_addr", m_addr, 0);
        ack_force = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_busy", m_busy, 0);
        chk("late_ack_req", m_req, 0);
        ack_force = 1'b0;
        run_scan(1'b0, 1, 0, 0);
        chk("rescan_done_cycle", obs_done, 1 + 81*3 + 1);
        chk("rescan_req_cycles", obs_req, 1);

        // no skipping, all-zero board
        clear_board();
        run_scan(1'b1, 1, 0, 0);
        chk("noskip_done_cycle", obs_done, 325);
        chk("noskip_req_cycles", obs_req, 81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
